// File: rtl/snake_tick_ctrl_pkg.sv
// Shared definitions for the snake game-speed controller: state encodings and default
// period constants, also used by the snake movement FSM.
package snake_tick_ctrl_pkg;

   localparam int unsigned PeriodW = 20;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StOver  = 2'd3
   } state_e;

   localparam logic [PeriodW-1:0] DefBasePeriod   = 20'd500000;
   localparam logic [PeriodW-1:0] DefStep         = 20'd40000;
   localparam logic [PeriodW-1:0] DefMinPeriod    = 20'd100000;
   localparam int unsigned        DefFoodPerLevel = 4;
   localparam int unsigned        DefLevelW       = 4;
   localparam int unsigned        DefMaxLevel     = 10;

endpackage

// File: rtl/snake_tick_ctrl_edge_pulse.sv
// One-cycle pulse on the rising edge of an already-synchronised level input.
module snake_tick_ctrl_edge_pulse (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_level,
   output logic o_pulse
);

   logic r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= i_level;
      end
   end

   assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/snake_tick_ctrl.sv
// Game-speed controller: drives the period counter's max/en, emits move_tick once per period
// and shortens the period as the level rises.
module snake_tick_ctrl
   import snake_tick_ctrl_pkg::*;
#(
   parameter logic [PeriodW-1:0] BASE_PERIOD    = DefBasePeriod,
   parameter logic [PeriodW-1:0] STEP           = DefStep,
   parameter logic [PeriodW-1:0] MIN_PERIOD     = DefMinPeriod,
   parameter int unsigned        FOOD_PER_LEVEL = DefFoodPerLevel,
   parameter int unsigned        LEVEL_W        = DefLevelW,
   parameter int unsigned        MAX_LEVEL      = DefMaxLevel
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [PeriodW-1:0] i_count,
   input  logic               i_start_btn,
   input  logic               i_pause_btn,
   input  logic               i_food_eaten,
   input  logic               i_collision,
   output logic [PeriodW-1:0] o_max,
   output logic               o_en,
   output logic               o_move_tick,
   output logic [LEVEL_W-1:0] o_level,
   output logic [1:0]         o_state
);

   localparam int unsigned FoodW = (FOOD_PER_LEVEL > 1) ? $clog2(FOOD_PER_LEVEL) : 1;
   localparam int unsigned CalcW = PeriodW + LEVEL_W;

   state_e             r_state, w_state_next;
   logic               w_start_edge, w_pause_edge;
   logic               r_en, r_tick, w_en_next, w_tick_next;
   logic [FoodW-1:0]   r_food;
   logic [LEVEL_W-1:0] r_level;
   logic [PeriodW-1:0] r_max, w_max_last, w_target;
   logic               r_pending, r_armed;
   logic               w_food_ok, w_food_wrap, w_level_up, w_restart, w_max_update;
   logic [CalcW-1:0]   w_reduction, w_diff;

   snake_tick_ctrl_edge_pulse u_start_edge (
      .i_clk   (i_clock),
      .i_rst   (i_reset),
      .i_level (i_start_btn),
      .o_pulse (w_start_edge)
   );

   snake_tick_ctrl_edge_pulse u_pause_edge (
      .i_clk   (i_clock),
      .i_rst   (i_reset),
      .i_level (i_pause_btn),
      .o_pulse (w_pause_edge)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (w_start_edge) w_state_next = StRun;
         StRun: begin
            if (i_collision) begin
               w_state_next = StOver;
            end else if (w_pause_edge) begin
               w_state_next = StPause;
            end
         end
         StPause: if (w_pause_edge) w_state_next = StRun;
         StOver:  if (w_start_edge) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Tick is gated by the next state so it never appears outside RUN.
   always_comb begin
      w_en_next   = (w_state_next == StRun);
      w_tick_next = (r_state == StRun) && r_en && (i_count == w_max_last)
                    && (w_state_next == StRun);
   end

   assign w_max_last = r_max - PeriodW'(1);

   // Collision beats pause beats food within a RUN cycle.
   assign w_food_ok    = (r_state == StRun) && i_food_eaten && !i_collision && !w_pause_edge;
   assign w_food_wrap  = w_food_ok && (r_food == FoodW'(FOOD_PER_LEVEL - 1));
   assign w_level_up   = w_food_wrap && (r_level < LEVEL_W'(MAX_LEVEL));
   assign w_restart    = (r_state == StOver) && w_start_edge;
   assign w_max_update = r_pending && (r_tick || r_armed) && (i_count == '0);

   // Widened arithmetic so a reduction beyond BASE_PERIOD clamps instead of wrapping.
   assign w_reduction = CalcW'(r_level) * CalcW'(STEP);
   assign w_diff      = CalcW'(BASE_PERIOD) - w_reduction;
   assign w_target    = ((w_reduction > CalcW'(BASE_PERIOD)) || (w_diff < CalcW'(MIN_PERIOD)))
                        ? MIN_PERIOD : w_diff[PeriodW-1:0];

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_en      <= 1'b0;
         r_tick    <= 1'b0;
         r_food    <= '0;
         r_level   <= '0;
         r_max     <= BASE_PERIOD;
         r_pending <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         r_en   <= w_en_next;
         r_tick <= w_tick_next;
         if (w_restart) begin
            r_food    <= '0;
            r_level   <= '0;
            r_max     <= BASE_PERIOD;
            r_pending <= 1'b0;
            r_armed   <= 1'b0;
         end else begin
            if (w_food_ok) begin
               r_food <= w_food_wrap ? '0 : r_food + 1'b1;
            end
            if (w_level_up) begin
               r_level <= r_level + 1'b1;
            end
            // max only moves at the end of a count==0 cycle, so a period never sees two values.
            if (w_max_update) begin
               r_max   <= w_target;
               r_armed <= 1'b0;
            end else if (r_tick && r_pending) begin
               r_armed <= 1'b1;
            end
            if (w_level_up) begin
               r_pending <= 1'b1;
            end else if (w_max_update) begin
               r_pending <= 1'b0;
            end
         end
      end
   end

   assign o_max       = r_max;
   assign o_en        = r_en;
   assign o_move_tick = r_tick;
   assign o_level     = r_level;
   assign o_state     = r_state;

endmodule

// File: tb/tb_snake_tick_ctrl.sv
// Bench for snake_tick_ctrl paired with a behavioural period counter.
module tb_snake_tick_ctrl;

   localparam int BASE = 20;
   localparam int STEP = 4;
   localparam int MINP = 8;
   localparam int FPL  = 2;
   localparam int MAXL = 5;
   localparam int LW   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, pause = 1'b0, food = 1'b0, coll = 1'b0;
   logic [19:0]   cnt = '0;
   logic [19:0]   o_max;
   logic          o_en, o_move_tick;
   logic [LW-1:0] o_level;
   logic [1:0]    o_state;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // The period counter this block closes the loop with; never reset by the controller.
   always @(posedge clk) begin
      if (o_en) cnt <= (cnt == o_max - 20'd1) ? 20'd0 : cnt + 20'd1;
   end

   snake_tick_ctrl #(
      .BASE_PERIOD    (20'(BASE)),
      .STEP           (20'(STEP)),
      .MIN_PERIOD     (20'(MINP)),
      .FOOD_PER_LEVEL (FPL),
      .LEVEL_W        (LW),
      .MAX_LEVEL      (MAXL)
   ) u_dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_count      (cnt),
      .i_start_btn  (start),
      .i_pause_btn  (pause),
      .i_food_eaten (food),
      .i_collision  (coll),
      .o_max        (o_max),
      .o_en         (o_en),
      .o_move_tick  (o_move_tick),
      .o_level      (o_level),
      .o_state      (o_state)
   );

   // Reference model: game rules at the cycle level, kept in plain integers.
   int m_state, m_level, m_food, m_max, m_cnt;
   bit m_en, m_tick, m_pending, m_sprev, m_pprev;

   function automatic int target(input int lvl);
      int t;
      t = BASE - lvl * STEP;
      return (t < MINP) ? MINP : t;
   endfunction

   task automatic model_reset();
      m_state = 0; m_level = 0; m_food = 0; m_max = BASE;
      m_en = 0; m_tick = 0; m_pending = 0; m_sprev = 0; m_pprev = 0;
   endtask

   task automatic model_step();
      bit se, pe, tick_cond;
      int ns, ncnt;
      se = start && !m_sprev;
      pe = pause && !m_pprev;
      tick_cond = (m_state == 1) && m_en && (m_cnt == m_max - 1);
      ncnt = m_en ? ((m_cnt == m_max - 1) ? 0 : m_cnt + 1) : m_cnt;
      // The tick cycle is the counter's count==0 cycle: an outstanding level change lands here.
      if (m_tick && m_pending) begin
         m_max = target(m_level);
         m_pending = 0;
      end
      ns = m_state;
      case (m_state)
         0: if (se) ns = 1;
         1: begin
            if (coll) ns = 3;
            else if (pe) ns = 2;
            else if (food) begin
               m_food++;
               if (m_food == FPL) begin
                  m_food = 0;
                  if (m_level < MAXL) begin
                     m_level++;
                     m_pending = 1;
                  end
               end
            end
         end
         2: if (pe) ns = 1;
         default: if (se) begin
            ns = 0; m_level = 0; m_food = 0; m_pending = 0; m_max = BASE;
         end
      endcase
      m_tick  = tick_cond && (ns == 1);
      m_en    = (ns == 1);
      m_state = ns;
      m_cnt   = ncnt;
      m_sprev = start;
      m_pprev = pause;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cycle();
      if (rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      check("model_state", int'(o_state), m_state);
      check("model_en", int'(o_en), int'(m_en));
      check("model_tick", int'(o_move_tick), int'(m_tick));
      check("model_level", int'(o_level), m_level);
      check("model_max", int'(o_max), m_max);
      check("model_count", int'(cnt), m_cnt);
   endtask

   task automatic wait_tick(input int budget, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!o_move_tick && n < budget);
      if (!o_move_tick) check("tick_timeout", 0, 1);
   endtask

   typedef struct {
      int s, p, f, c;
      int st, en, lv, mx;
   } vec_t;

   vec_t vq[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int ticks;
      m_cnt = 0;
      model_reset();

      // Reset values
      cycle();
      cycle();
      check("rst_state", int'(o_state), 0);
      check("rst_en", int'(o_en), 0);
      check("rst_tick", int'(o_move_tick), 0);
      check("rst_level", int'(o_level), 0);
      check("rst_max", int'(o_max), BASE);
      rst = 1'b0;

      // Table: start/pause/food/collision events and the state they must leave behind.
      vq.push_back('{1, 0, 0, 0, 1, 1, 0, 20});
      vq.push_back('{1, 0, 0, 0, 1, 1, 0, 20});
      vq.push_back('{0, 0, 1, 0, 1, 1, 0, 20});
      vq.push_back('{0, 0, 1, 0, 1, 1, 1, 20});
      vq.push_back('{0, 1, 0, 0, 2, 0, 1, 20});
      vq.push_back('{0, 1, 1, 0, 2, 0, 1, 20});
      vq.push_back('{0, 0, 0, 1, 2, 0, 1, 20});
      vq.push_back('{0, 1, 0, 0, 1, 1, 1, 20});
      vq.push_back('{0, 0, 1, 0, 1, 1, 1, 20});
      vq.push_back('{0, 0, 1, 1, 3, 0, 1, 20});
      vq.push_back('{0, 0, 1, 0, 3, 0, 1, 20});
      vq.push_back('{1, 0, 0, 0, 0, 0, 0, 20});
      vq.push_back('{1, 0, 0, 0, 0, 0, 0, 20});
      vq.push_back('{0, 0, 0, 0, 0, 0, 0, 20});
      vq.push_back('{1, 0, 0, 0, 1, 1, 0, 20});
      vq.push_back('{0, 0, 1, 0, 1, 1, 0, 20});
      vq.push_back('{0, 0, 1, 0, 1, 1, 1, 20});
      foreach (vq[i]) begin
         start = (vq[i].s != 0);
         pause = (vq[i].p != 0);
         food  = (vq[i].f != 0);
         coll  = (vq[i].c != 0);
         cycle();
         check($sformatf("vec%0d_state", i), int'(o_state), vq[i].st);
         check($sformatf("vec%0d_en", i), int'(o_en), vq[i].en);
         check($sformatf("vec%0d_level", i), int'(o_level), vq[i].lv);
         check($sformatf("vec%0d_max", i), int'(o_max), vq[i].mx);
      end
      start = 0; pause = 0; food = 0; coll = 0;

      // 1: start held high, ticks every BASE clocks
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      start = 1'b1;
      wait_tick(60, n);
      wait_tick(40, n);
      check("t1_gap_a", n, BASE);
      wait_tick(40, n);
      check("t1_gap_b", n, BASE);
      check("t1_state", int'(o_state), 1);
      start = 1'b0;

      // 2: level-up defers the new max to the end of the next tick's count==0 cycle
      food = 1'b1; cycle();
      food = 1'b0; cycle();
      food = 1'b1; cycle();
      food = 1'b0; cycle();
      check("t2_level", int'(o_level), 1);
      check("t2_max_hold", int'(o_max), BASE);
      wait_tick(40, n);
      check("t2_max_at_tick", int'(o_max), BASE);
      cycle();
      check("t2_max_new", int'(o_max), BASE - STEP);
      wait_tick(40, n);
      check("t2_gap_a", n + 1, BASE - STEP);
      wait_tick(40, n);
      check("t2_gap_b", n, BASE - STEP);

      // 3: saturation and clamp
      for (int i = 0; i < 10; i++) begin
         food = 1'b1; cycle();
         food = 1'b0; cycle();
      end
      for (int i = 0; i < 4; i++) begin
         wait_tick(40, n);
         check($sformatf("t3_gap%0d_le_base", i), int'(n <= BASE), 1);
      end
      check("t3_gap_min", n, MINP);
      check("t3_level_sat", int'(o_level), MAXL);
      check("t3_max_clamp", int'(o_max), MINP);

      // 4: pause freezes the counter, resume continues from the same count
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      start = 1'b1; cycle();
      start = 1'b0;
      n = 0;
      while (cnt != 20'd6 && n < 40) begin
         cycle();
         n++;
      end
      check("t4_reach6", int'(cnt), 6);
      pause = 1'b1;
      cycle();
      ticks = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         ticks += int'(o_move_tick);
      end
      check("t4_state", int'(o_state), 2);
      check("t4_en", int'(o_en), 0);
      check("t4_frozen", int'(cnt), 7);
      check("t4_no_tick", ticks, 0);
      pause = 1'b0; cycle();
      pause = 1'b1; cycle();
      pause = 1'b0;
      check("t4_resume_en", int'(o_en), 1);
      check("t4_resume_cnt", int'(cnt), 7);
      wait_tick(40, n);
      check("t4_resume_tick", n, BASE - 7);

      // 5: collision suppresses same-cycle food, restart clears level and period
      food = 1'b1; cycle();
      food = 1'b0; cycle();
      food = 1'b1; cycle();
      food = 1'b0; cycle();
      food = 1'b1; cycle();
      food = 1'b0; cycle();
      food = 1'b1; coll = 1'b1; cycle();
      food = 1'b0; coll = 1'b0;
      check("t5_state_over", int'(o_state), 3);
      check("t5_level_kept", int'(o_level), 1);
      check("t5_en", int'(o_en), 0);
      start = 1'b1; cycle();
      start = 1'b0;
      check("t5_state_idle", int'(o_state), 0);
      check("t5_level_clr", int'(o_level), 0);
      check("t5_max_base", int'(o_max), BASE);
      cycle();

      // 6: asynchronous reset between edges
      start = 1'b1; cycle();
      start = 1'b0;
      food = 1'b1; cycle();
      food = 1'b0; cycle();
      food = 1'b1; cycle();
      food = 1'b0; cycle();
      wait_tick(40, n);
      wait_tick(40, n);
      check("t6_pre_max", int'(o_max), BASE - STEP);
      #2;
      rst = 1'b1;
      #1;
      check("t6_async_state", int'(o_state), 0);
      check("t6_async_en", int'(o_en), 0);
      check("t6_async_level", int'(o_level), 0);
      check("t6_async_max", int'(o_max), BASE);
      check("t6_async_tick", int'(o_move_tick), 0);
      model_reset();
      cycle();
      rst = 1'b0;

      // Randomised play against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) start = ~start;
         if ($urandom_range(0, 19) == 0) pause = ~pause;
         food = ($urandom_range(0, 4) == 0);
         coll = ($urandom_range(0, 199) == 0);
         rst  = ($urandom_range(0, 999) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
